// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage: owns the program counter, issues in-order imem
// requests under a credit limit, buffers responses and hands {pc, instr} to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [31:0]            imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [31:0]            imem_rsp_data,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [31:0]            id_pc,
   output logic [31:0]            id_instruction,
   output logic [$clog2(DEPTH):0] outstanding
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   fifo_pc_q    [DEPTH];
   logic [31:0]   fifo_instr_q [DEPTH];

   logic          has_head;
   logic          id_fire;
   logic          req_fire;
   logic          dropping;
   logic          push;
   logic          pop;
   logic [CW:0]   credit;
   logic [31:0]   redirect_aligned;

   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
   assign has_head         = (count_q != '0);

   assign id_valid = has_head & ~redirect_valid;
   assign id_fire  = id_valid & id_ready;

   // In-flight requests plus buffered entries may never exceed the buffer,
   // so every response that is kept always has a free slot.
   assign credit         = {1'b0, outst_q} + {1'b0, count_q} - (CW+1)'(id_fire);
   assign imem_req_valid = rst_n & ~redirect_valid & (credit < CREDIT_MAX);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign dropping = (drop_q != '0);
   assign push     = imem_rsp_valid & ~redirect_valid & ~dropping;
   assign pop      = id_fire;

   assign id_pc          = has_head ? fifo_pc_q[rd_ptr_q]    : 32'h0;
   assign id_instruction = has_head ? fifo_instr_q[rd_ptr_q] : NOP;
   assign outstanding    = outst_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (redirect_valid) begin
         // Everything still in flight belongs to the old path, except a
         // response landing right now, which is simply ignored.
         fetch_pc_d = redirect_aligned;
         rsp_pc_d   = redirect_aligned;
         outst_d    = outst_q - CW'(imem_rsp_valid);
         drop_d     = outst_q - CW'(imem_rsp_valid);
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
         count_d = count_q + CW'(push) - CW'(pop);
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_rsp_valid && dropping) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
      end
   end

   fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && count_q == FULL));

   rsp_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && outst_q == '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table for streaming,
// backpressure and memory stalls, plus hand-written redirect and wrap sequences.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'hDEAD_BEEF;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   logic [31:0] id_pc;
   logic [31:0] id_instruction;
   logic [1:0]  outstanding;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_q [$];
   logic [31:0] got_q [$];
   logic        rsp_hold = 1'b0;

   typedef struct {
      logic        idr;
      logic        mrdy;
      logic        rv;
      logic [31:0] addr;
      logic        idv;
      logic [31:0] pc;
      logic [1:0]  outs;
   } vec_t;

   vec_t tbl [22];

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instruction (id_instruction),
      .outstanding    (outstanding)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_5A00;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Memory: accepts every request, answers in order one cycle later unless held.
   always @(posedge clk) begin
      if (!rst_n) mem_q.delete();
      else if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
      #2;
      if (rst_n && !rsp_hold && mem_q.size() != 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_at(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
   end

   always @(posedge clk) begin
      if (rst_n && id_valid && id_ready) begin
         got_q.push_back(id_pc);
         chk("fire", "instr", id_instruction, word_at(id_pc));
      end
   end

   task automatic do_reset();
      rst_n          = 1'b0;
      id_ready       = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #1;
      chk("reset", "rv",    32'(imem_req_valid), 32'h0);
      chk("reset", "addr",  imem_req_addr, 32'h100);
      chk("reset", "idv",   32'(id_valid), 32'h0);
      chk("reset", "pc",    id_pc, 32'h0);
      chk("reset", "instr", id_instruction, NOP);
      chk("reset", "outs",  32'(outstanding), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got_q.delete();
   endtask

   task automatic cyc(input string nm, input logic idr, input logic mrdy, input logic redir,
                      input logic [31:0] rpc, input logic e_rv, input logic [31:0] e_addr,
                      input logic e_idv, input logic [31:0] e_pc, input logic [1:0] e_out);
      logic [31:0] e_instr;
      id_ready       = idr;
      imem_req_ready = mrdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      e_instr = (e_idv || e_pc != 32'h0) ? word_at(e_pc) : NOP;
      @(negedge clk);
      chk(nm, "rv",    32'(imem_req_valid), 32'(e_rv));
      chk(nm, "addr",  imem_req_addr, e_addr);
      chk(nm, "idv",   32'(id_valid), 32'(e_idv));
      chk(nm, "pc",    id_pc, e_pc);
      chk(nm, "instr", id_instruction, e_instr);
      chk(nm, "outs",  32'(outstanding), 32'(e_out));
      @(posedge clk);
      #1;
   endtask

   initial begin
      // streaming from 0x100
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   2'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   2'd1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 2'd1};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 2'd1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108, 2'd1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C, 2'd1};
      // decode stalled for 6 cycles: buffer fills, requests stop
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h110, 2'd1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h110, 2'd0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h110, 2'd0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h110, 2'd0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h110, 2'd0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b1, 32'h110, 2'd0};
      // requests resume in the first id_fire cycle
      tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h118, 1'b1, 32'h110, 2'd0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h114, 2'd1};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h118, 2'd1};
      // memory not ready for 4 cycles: address held
      tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h124, 1'b1, 32'h11C, 2'd1};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 32'h124, 1'b1, 32'h120, 2'd0};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 32'h124, 1'b0, 32'h0,   2'd0};
      tbl[18] = '{1'b1, 1'b0, 1'b1, 32'h124, 1'b0, 32'h0,   2'd0};
      tbl[19] = '{1'b1, 1'b1, 1'b1, 32'h124, 1'b0, 32'h0,   2'd0};
      tbl[20] = '{1'b1, 1'b1, 1'b1, 32'h128, 1'b0, 32'h0,   2'd1};
      tbl[21] = '{1'b1, 1'b1, 1'b1, 32'h12C, 1'b1, 32'h124, 2'd1};

      #1;
      do_reset();
      for (int i = 0; i < 22; i++) begin
         cyc($sformatf("t%0d", i), tbl[i].idr, tbl[i].mrdy, 1'b0, 32'h0,
             tbl[i].rv, tbl[i].addr, tbl[i].idv, tbl[i].pc, tbl[i].outs);
      end
      chk("stream", "n", 32'(got_q.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < got_q.size()) chk($sformatf("stream%0d", i), "pc", got_q[i], 32'h100 + 32'(4 * i));
      end

      // redirect with two requests in flight (responses held back)
      rsp_hold = 1'b1;
      do_reset();
      cyc("rdA0", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h100,  1'b0, 32'h0,    2'd0);
      cyc("rdA1", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h104,  1'b0, 32'h0,    2'd1);
      cyc("rdA2", 1'b1, 1'b1, 1'b1, 32'h2002, 1'b0, 32'h108,  1'b0, 32'h0,    2'd2);
      rsp_hold = 1'b0;
      cyc("rdA3", 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h2000, 1'b0, 32'h0,    2'd2);
      cyc("rdA4", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2000, 1'b0, 32'h0,    2'd1);
      cyc("rdA5", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2004, 1'b0, 32'h0,    2'd1);
      cyc("rdA6", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2008, 1'b1, 32'h2000, 2'd1);
      chk("rdA", "n", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("rdA", "first", got_q[0], 32'h2000);

      // redirect colliding with a response and a ready decode, then wrap at 2^32
      do_reset();
      cyc("rdB0", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h100,  1'b0, 32'h0,    2'd0);
      cyc("rdB1", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h104,  1'b0, 32'h0,    2'd1);
      cyc("rdB2", 1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h108,  1'b0, 32'h100,  2'd1);
      cyc("rdB3", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3000, 1'b0, 32'h0,    2'd0);
      cyc("rdB4", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3004, 1'b0, 32'h0,    2'd1);
      chk("rdB", "nofire", 32'(got_q.size()), 32'd0);
      cyc("rdB5", 1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3008, 1'b1, 32'h3000, 2'd1);
      cyc("wr6",  1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 32'h300C, 1'b0, 32'h3004, 2'd1);
      cyc("wr7",  1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         2'd0);
      cyc("wr8",  1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         2'd1);
      cyc("wr9",  1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8, 2'd1);
      cyc("wr10", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 2'd1);
      cyc("wr11", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 2'd1);
      chk("wrap", "n", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk("wrap", "pc0", got_q[0], 32'h3000);
         chk("wrap", "pc1", got_q[1], 32'hFFFF_FFF8);
         chk("wrap", "pc2", got_q[2], 32'hFFFF_FFFC);
         chk("wrap", "pc3", got_q[3], 32'h0000_0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
